// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory port: word-organised RAM behind valid/ready
// request and response channels, with RV32I load/store sizing and programmable wait states.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [2:0]    func3_q, func3_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        reqIllegal, reqMisaligned, reqRange, reqErr;
    logic [31:0] memWord, loadData, storeData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [3:0]  storeBe;
    logic        doAccess;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign doAccess  = (state_q == ST_WAIT) && (cnt_q == 4'd0);

    // Bad accesses are judged on the incoming fields so they can skip the wait states entirely.
    always_comb begin
        reqIllegal    = req_write ? (req_func3 > 3'b010)
                                  : !(req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        reqMisaligned = ((req_func3[1:0] == 2'b01) && req_addr[0])
                     || ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        reqRange      = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        reqErr        = reqIllegal || reqMisaligned || reqRange;
    end

    always_comb begin
        memWord = mem[idx_q];
        case (off_q)
            2'd0:    byteSel = memWord[7:0];
            2'd1:    byteSel = memWord[15:8];
            2'd2:    byteSel = memWord[23:16];
            default: byteSel = memWord[31:24];
        endcase
        halfSel = off_q[1] ? memWord[31:16] : memWord[15:0];
        case (func3_q)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b010:  loadData = memWord;
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick what lands in RAM.
    always_comb begin
        case (func3_q[1:0])
            2'b00: begin
                storeData = {4{wdata_q[7:0]}};
                storeBe   = 4'b0001 << off_q;
            end
            2'b01: begin
                storeData = {2{wdata_q[15:0]}};
                storeBe   = off_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = wdata_q;
                storeBe   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        func3_d = func3_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    func3_d = req_func3;
                    idx_d   = req_addr[AW+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (reqErr) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = write_q ? 32'd0 : loadData;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            func3_q <= 3'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            func3_q <= func3_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared; an asynchronous reset drops state_q out of WAIT, cancelling the commit.
    always_ff @(posedge clk) begin
        if (doAccess && write_q) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (storeBe[lane]) begin
                    mem[idx_q][8*lane +: 8] <= storeData[8*lane +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a table of load/store vectors with expected data,
// error flag and latency, plus hand-written reset, backpressure and reset-mid-access sequences.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request with rsp_ready high and returns data, error and cycles from accept to rsp_valid.
    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                 output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptReady", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        rst       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        vecs.push_back('{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 4});
        vecs.push_back('{1'b1, 3'b000, 32'h011, 32'h00000080, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 3'b000, 32'h011, 32'h0,        32'hFFFFFF80, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b100, 32'h011, 32'h0,        32'h00000080, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEAD80EF, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b010, 32'h013, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 3'b001, 32'h021, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 3'b010, 32'h012, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEAD80EF, 1'b0, 4});
        vecs.push_back('{1'b1, 3'b010, 32'h014, 32'h11223344, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b1, 3'b001, 32'h016, 32'hFFFFABCD, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 3'b010, 32'h014, 32'h0,        32'hABCD3344, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b101, 32'h016, 32'h0,        32'h0000ABCD, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b001, 32'h016, 32'h0,        32'hFFFFABCD, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b000, 32'h014, 32'h0,        32'h00000044, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b100, 32'h017, 32'h0,        32'h000000AB, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b000, 32'h017, 32'h0,        32'hFFFFFFAB, 1'b0, 4});
        vecs.push_back('{1'b0, 3'b001, 32'h011, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 3'b100, 32'h010, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b0, 3'b110, 32'h010, 32'h0,        32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0, 4});
        vecs.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0, 4});
        vecs.push_back('{1'b1, 3'b010, 32'h1000, 32'h1,       32'h0,        1'b1, 1});
        vecs.push_back('{1'b1, 3'b010, 32'h020, 32'h0BADF00D, 32'h0,        1'b0, 4});

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstBusy",     {31'd0, busy},      32'd0);
        checkOutput("rstRdata",    rsp_rdata,          32'd0);
        checkOutput("rstErr",      {31'd0, rsp_err},   32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("postRstBusy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
        end

        // Backpressure: response held for 5 cycles while the next request waits.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h10;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_addr  = 32'h14;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bpValid%0d", k), {31'd0, rsp_valid}, 32'd1);
            checkOutput($sformatf("bpRdata%0d", k), rsp_rdata, 32'hDEAD80EF);
            checkOutput($sformatf("bpReqReady%0d", k), {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        checkOutput("bpNoTurnaround", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("bpIdleValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("bpIdleReady", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bpQueuedBusy", {31'd0, busy}, 32'd1);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bpQueuedRdata", rsp_rdata, 32'hABCD3344);
        @(negedge clk);
        checkOutput("bpEndIdle", {31'd0, busy}, 32'd0);

        // Reset while the store is still counting down: prior contents must survive.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midRstBusy",  {31'd0, busy},      32'd0);
        checkOutput("midRstReady", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checkOutput("midRstRdata", rd, 32'h0BADF00D);
        checkOutput("midRstErr", {31'd0, er}, 32'd0);
        checkOutput("midRstLatency", 32'(lat), 32'd4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
